// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI instruction fetch path.
// The fetch-entry pc field is 32 bits wide, so fetch address widths up to 32 bits are supported.
package arm7tdmi_pkg;

  localparam int unsigned ARM_INSTR_BYTES   = 32'd4;
  localparam int unsigned THUMB_INSTR_BYTES = 32'd2;
  localparam int unsigned PC_WIDTH          = 32'd32;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic                thumb;
  } fetch_entry_t;

  // Byte distance to the next sequential instruction in the given mode.
  function automatic int unsigned instr_bytes(input logic thumb_mode);
    return thumb_mode ? THUMB_INSTR_BYTES : ARM_INSTR_BYTES;
  endfunction

endpackage

// File: rtl/arm7tdmi_fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer of fetch entries with flush.
// The head is read straight out of the storage registers.
module arm7tdmi_fetch_fifo
  import arm7tdmi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_s;
  logic            full_s;
  logic            do_push_s;
  logic            do_pop_s;

  // Qualify push/pop against occupancy; a full queue may push only while popping.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && (!full_s || do_pop_s);
    if (flush) begin
      count_s = {CW{1'b0}};
    end else begin
      count_s = count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Pointer and occupancy registers; flush empties the queue on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_s;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  assign head       = mem_r[rd_ptr_r];
  assign valid      = (count_r != {CW{1'b0}});
  assign count      = count_r;
  assign count_next = count_s;

endmodule

// File: rtl/arm7tdmi_prefetch_unit.sv
// Instruction prefetch stage: issues single outstanding icache requests, queues
// returned instructions for decode, and restarts fetching on branch redirects.
module arm7tdmi_prefetch_unit
  import arm7tdmi_pkg::*;
#(
  parameter int                    DEPTH        = 4,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_enable,
  output logic [ADDR_WIDTH-1:0]  ic_addr,
  output logic                   ic_req,
  output logic                   ic_thumb_mode,
  input  logic [31:0]            ic_data,
  input  logic                   ic_ready,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   branch_thumb,
  output logic                   dec_valid,
  output logic [31:0]            dec_instr,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  output logic                   dec_thumb,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   fetch_busy
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t   state_r, state_s;
  logic           req_r, req_s;
  logic [AW-1:0]  addr_r, addr_s;
  logic           tm_r, tm_s;
  logic [AW-1:0]  pc_r, pc_s;
  logic           thumb_r, thumb_s;

  logic           push_s;
  logic           pop_s;
  logic           can_issue_s;
  logic [AW-1:0]  target_s;
  logic [AW-1:0]  align_mask_s;
  logic [CW-1:0]  count_next_s;
  logic [PC_WIDTH-1:0] pc_ext_s;
  fetch_entry_t   push_entry_s;
  fetch_entry_t   head_s;

  // Branches win over both push and pop: a same-cycle response is dropped and the head is not consumed.
  always_comb begin
    push_s       = (state_r == FS_FETCH) && ic_ready && !branch_valid;
    pop_s        = dec_ready && dec_valid && !branch_valid;
    align_mask_s = branch_thumb ? AW'(1) : AW'(3);
    target_s     = branch_target & ~align_mask_s;
    if (branch_valid) begin
      pc_s    = target_s;
      thumb_s = branch_thumb;
    end else if (push_s) begin
      pc_s    = pc_r + AW'(instr_bytes(thumb_r));
      thumb_s = thumb_r;
    end else begin
      pc_s    = pc_r;
      thumb_s = thumb_r;
    end
    can_issue_s = fetch_enable && (count_next_s < CW'(DEPTH));
  end

  // Next-state and next-request logic; a request is held until the cache completes it.
  always_comb begin
    state_s = state_r;
    req_s   = req_r;
    addr_s  = addr_r;
    tm_s    = tm_r;
    case (state_r)
      FS_IDLE: begin
        if (can_issue_s) begin
          state_s = FS_FETCH;
          req_s   = 1'b1;
          addr_s  = pc_s;
          tm_s    = thumb_s;
        end else begin
          state_s = FS_IDLE;
          req_s   = 1'b0;
        end
      end
      FS_FETCH, FS_DISCARD: begin
        if (ic_ready) begin
          if (can_issue_s) begin
            state_s = FS_FETCH;
            req_s   = 1'b1;
            addr_s  = pc_s;
            tm_s    = thumb_s;
          end else begin
            state_s = FS_IDLE;
            req_s   = 1'b0;
          end
        end else if (branch_valid) begin
          state_s = FS_DISCARD;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = FS_IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // FSM, request and fetch-PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FS_IDLE;
      req_r   <= 1'b0;
      addr_r  <= RESET_VECTOR;
      tm_r    <= 1'b0;
      pc_r    <= RESET_VECTOR;
      thumb_r <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
      tm_r    <= tm_s;
      pc_r    <= pc_s;
      thumb_r <= thumb_s;
    end
  end

  // Widen the request address into the queue's fixed-width pc field.
  always_comb begin
    pc_ext_s           = {PC_WIDTH{1'b0}};
    pc_ext_s[AW-1:0]   = addr_r;
    push_entry_s.instr = ic_data;
    push_entry_s.pc    = pc_ext_s;
    push_entry_s.thumb = tm_r;
  end

  arm7tdmi_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_valid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .valid      (dec_valid),
    .count      (queue_count),
    .count_next (count_next_s)
  );

  assign ic_addr       = addr_r;
  assign ic_req        = req_r;
  assign ic_thumb_mode = tm_r;
  assign dec_instr     = head_s.instr;
  assign dec_pc        = head_s.pc[AW-1:0];
  assign dec_thumb     = head_s.thumb;
  assign fetch_busy    = (state_r != FS_IDLE);

endmodule

// File: tb/tb_arm7tdmi_prefetch_unit.sv
// Directed bench for arm7tdmi_prefetch_unit with a behavioural icache and decode logger.
module tb_arm7tdmi_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_enable;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic        ic_thumb_mode;
  logic [31:0] ic_data  = 32'h0;
  logic        ic_ready = 1'b0;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        branch_thumb;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_thumb;
  logic        dec_ready;
  logic [2:0]  queue_count;
  logic        fetch_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int wcnt    = 0;
  logic hold  = 1'b0;

  logic [31:0] addr_log [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_instr [$];
  logic [31:0] pop_thumb [$];

  arm7tdmi_prefetch_unit #(
    .DEPTH        (4),
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_enable  (fetch_enable),
    .ic_addr       (ic_addr),
    .ic_req        (ic_req),
    .ic_thumb_mode (ic_thumb_mode),
    .ic_data       (ic_data),
    .ic_ready      (ic_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .branch_thumb  (branch_thumb),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_thumb     (dec_thumb),
    .dec_ready     (dec_ready),
    .queue_count   (queue_count),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic t);
    return t ? {16'h0000, a[15:0] ^ 16'hBEEF} : (a ^ 32'hDEAD_0000);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Icache model: answers lat cycles after a request appears unless held; logs completed addresses.
  always @(negedge clk) begin
    if (rst || !ic_req) begin
      ic_ready = 1'b0;
      wcnt     = 0;
    end else if (ic_ready) begin
      ic_ready = 1'b0;
      wcnt     = 0;
    end else if (!hold && wcnt >= lat) begin
      ic_ready = 1'b1;
      ic_data  = mem_word(ic_addr, ic_thumb_mode);
      addr_log.push_back(ic_addr);
    end else begin
      wcnt++;
    end
  end

  // Decode-side logger: records every head that the coming edge will consume.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready && !branch_valid) begin
      pop_pc.push_back(dec_pc);
      pop_instr.push_back(dec_instr);
      pop_thumb.push_back({31'd0, dec_thumb});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    pop_thumb.delete();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    fetch_enable = 1'b0;
    dec_ready    = 1'b0;
    branch_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] t, input logic th);
    branch_target = t;
    branch_thumb  = th;
    branch_valid  = 1'b1;
    step(1);
    branch_valid  = 1'b0;
  endtask

  task automatic wait_addr(input int n, input string tag);
    int k = 0;
    while (addr_log.size() < n && k < 200) begin
      step(1);
      k++;
    end
    if (addr_log.size() < n) check_eq(tag, 32'(addr_log.size()), 32'(n));
  endtask

  task automatic wait_pop(input int n, input string tag);
    int k = 0;
    while (pop_pc.size() < n && k < 200) begin
      step(1);
      k++;
    end
    if (pop_pc.size() < n) check_eq(tag, 32'(pop_pc.size()), 32'(n));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    fetch_enable = 1'b0;
    dec_ready    = 1'b1;
    while ((fetch_busy || dec_valid) && k < 200) begin
      step(1);
      k++;
    end
    if (fetch_busy || dec_valid) check_eq(tag, {30'd0, fetch_busy, dec_valid}, 32'd0);
  endtask

  initial begin
    bit found;
    rst           = 1'b1;
    fetch_enable  = 1'b0;
    dec_ready     = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    branch_thumb  = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_ic_req", 32'(ic_req), 32'd0);
    check_eq("rst_ic_addr", ic_addr, 32'h0000_0000);
    check_eq("rst_thumb", 32'(ic_thumb_mode), 32'd0);
    check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_busy", 32'(fetch_busy), 32'd0);

    // Streaming ARM
    clear_logs();
    fetch_enable = 1'b1;
    dec_ready    = 1'b1;
    wait_pop(4, "stream_timeout");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("stream_pc%0d", i), pop_pc[i], 32'(4 * i));
      check_eq($sformatf("stream_instr%0d", i), pop_instr[i], mem_word(32'(4 * i), 1'b0));
    end
    drain("stream_drain");

    // Backpressure
    do_reset();
    clear_logs();
    fetch_enable = 1'b1;
    dec_ready    = 1'b0;
    step(40);
    check_eq("bp_count_full", 32'(queue_count), 32'd4);
    check_eq("bp_req_low", 32'(ic_req), 32'd0);
    check_eq("bp_issued", 32'(addr_log.size()), 32'd4);
    check_eq("bp_last_addr", addr_log[3], 32'h0000_000C);
    dec_ready = 1'b1;
    step(1);
    dec_ready = 1'b0;
    check_eq("bp_reissue_req", 32'(ic_req), 32'd1);
    check_eq("bp_reissue_addr", ic_addr, 32'h0000_0010);
    check_eq("bp_count_after_pop", 32'(queue_count), 32'd3);
    step(12);
    check_eq("bp_refill_count", 32'(queue_count), 32'd4);
    check_eq("bp_refill_req_low", 32'(ic_req), 32'd0);
    check_eq("bp_single_issue", 32'(addr_log.size()), 32'd5);

    // Thumb fetch after a branch
    clear_logs();
    dec_ready = 1'b1;
    branch_to(32'h0000_1022, 1'b1);
    wait_addr(3, "thumb_timeout");
    fetch_enable = 1'b0;
    wait_pop(1, "thumb_pop_timeout");
    check_eq("thumb_addr0", addr_log[0], 32'h0000_1022);
    check_eq("thumb_addr1", addr_log[1], 32'h0000_1024);
    check_eq("thumb_addr2", addr_log[2], 32'h0000_1026);
    check_eq("thumb_pc0", pop_pc[0], 32'h0000_1022);
    check_eq("thumb_instr0", pop_instr[0], mem_word(32'h0000_1022, 1'b1));
    check_eq("thumb_upper_zero", pop_instr[0] >> 16, 32'd0);
    check_eq("thumb_flag", pop_thumb[0], 32'd1);
    drain("thumb_drain");

    // Branch during a miss
    clear_logs();
    hold         = 1'b1;
    fetch_enable = 1'b1;
    dec_ready    = 1'b1;
    branch_to(32'h0000_1000, 1'b0);
    check_eq("miss_req", 32'(ic_req), 32'd1);
    check_eq("miss_addr", ic_addr, 32'h0000_1000);
    step(9);
    check_eq("miss_addr_held", ic_addr, 32'h0000_1000);
    branch_to(32'h0000_2001, 1'b0);
    check_eq("miss_flush_count", 32'(queue_count), 32'd0);
    check_eq("miss_flush_valid", 32'(dec_valid), 32'd0);
    check_eq("miss_discard_addr", ic_addr, 32'h0000_1000);
    check_eq("miss_discard_busy", 32'(fetch_busy), 32'd1);
    step(2);
    check_eq("miss_discard_held", ic_addr, 32'h0000_1000);
    hold = 1'b0;
    wait_addr(2, "miss_timeout");
    wait_pop(1, "miss_pop_timeout");
    check_eq("miss_old_completed", addr_log[0], 32'h0000_1000);
    check_eq("miss_next_addr", addr_log[1], 32'h0000_2000);
    check_eq("miss_first_pop", pop_pc[0], 32'h0000_2000);
    check_eq("miss_first_instr", pop_instr[0], mem_word(32'h0000_2000, 1'b0));
    drain("miss_drain");

    // Branch and pop in the same cycle as the 0xFFFFFFFC response
    clear_logs();
    fetch_enable = 1'b1;
    dec_ready    = 1'b1;
    branch_to(32'hFFFF_FFFC, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      #1;
      if (ic_ready && ic_addr == 32'hFFFF_FFFC) found = 1'b1;
    end
    if (!found) check_eq("simul_resp_seen", 32'd0, 32'd1);
    branch_target = 32'h0000_3000;
    branch_thumb  = 1'b0;
    branch_valid  = 1'b1;
    @(posedge clk);
    #1;
    branch_valid = 1'b0;
    check_eq("simul_dropped_count", 32'(queue_count), 32'd0);
    check_eq("simul_new_addr", ic_addr, 32'h0000_3000);
    check_eq("simul_new_req", 32'(ic_req), 32'd1);
    wait_pop(1, "simul_pop_timeout");
    check_eq("simul_first_pop", pop_pc[0], 32'h0000_3000);
    drain("simul_drain");

    // Address wrap without a mid-stream branch
    do_reset();
    clear_logs();
    fetch_enable = 1'b1;
    dec_ready    = 1'b1;
    branch_to(32'hFFFF_FFFC, 1'b0);
    wait_addr(2, "wrap_timeout");
    wait_pop(2, "wrap_pop_timeout");
    check_eq("wrap_addr0", addr_log[0], 32'hFFFF_FFFC);
    check_eq("wrap_addr1", addr_log[1], 32'h0000_0000);
    check_eq("wrap_pop0", pop_pc[0], 32'hFFFF_FFFC);
    check_eq("wrap_pop1", pop_pc[1], 32'h0000_0000);
    drain("wrap_drain");

    // Reset in the middle of a request
    hold         = 1'b1;
    fetch_enable = 1'b1;
    dec_ready    = 1'b0;
    branch_to(32'h0000_0500, 1'b0);
    step(2);
    check_eq("mid_req_pending", 32'(ic_req), 32'd1);
    check_eq("mid_req_addr", ic_addr, 32'h0000_0500);
    rst = 1'b1;
    step(1);
    check_eq("mid_rst_req", 32'(ic_req), 32'd0);
    check_eq("mid_rst_valid", 32'(dec_valid), 32'd0);
    check_eq("mid_rst_count", 32'(queue_count), 32'd0);
    check_eq("mid_rst_busy", 32'(fetch_busy), 32'd0);
    rst  = 1'b0;
    hold = 1'b0;
    clear_logs();
    wait_addr(1, "mid_restart_timeout");
    check_eq("mid_restart_addr", addr_log[0], 32'h0000_0000);
    drain("mid_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
